clkgen_prog_ctrl: RTL and testbench
===================================

CLKGEN_PROG_CTRL -- requirements
Module: clkgen_prog_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of DCM_CLKGEN tiles controlled (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 4096: CLK cycles allowed after GO for PROGDONE.
REQ-003 SHALL have port CLK  in  1: sole clock; also drives every tile's PROGCLK.
REQ-004 SHALL have port reset  in  1: synchronous, active-high.
REQ-005 SHALL have port req  in  1: program request, sampled only while ready=1.
REQ-006 SHALL have port ch_sel  in  3: target tile index.
REQ-007 SHALL have port m_minus1  in  8: M-1 (M = 2..256).
REQ-008 SHALL have port d_minus1  in  8: D-1 (D = 1..256).
REQ-009 SHALL have port ready  out  1: idle, able to accept req.
REQ-010 SHALL have port done  out  1: one-cycle pulse, programming completed.
REQ-011 SHALL have port err  out  1: one-cycle pulse, request failed.
REQ-012 SHALL have port err_code  out  2: 01 bad M, 10 bad channel, 11 timeout; valid with err.
REQ-013 SHALL have port PROGEN  out  N_CH: per-tile program enable.
REQ-014 SHALL have port PROGDATA  out  N_CH: per-tile serial data.
REQ-015 SHALL have port PROGDONE  in  N_CH: per-tile done flag (CLK domain, no synchroniser).

Function
REQ-016 SHALL accept a request on any edge with req=1 and ready=1 (cycle T); ch_sel, m_minus1, d_minus1 SHALL be captured at T.
REQ-017 SHALL reject at T when m_minus1=0 (err_code 01) or ch_sel>=N_CH (err_code 10); bad channel takes priority; err pulses at T+1, ready returns at T+1, and no PROGEN activity occurs.
REQ-018 SHALL sequence states IDLE -> LOAD_D -> GAP1 -> LOAD_M -> GAP2 -> GO -> WAIT_DONE -> IDLE.
REQ-019 LOAD_D SHALL drive PROGEN=1 for cycles T+1..T+10 with PROGDATA = 1, 0, then d_minus1 bits 0..7 (LSB first).
REQ-020 GAP1 (T+11..T+12) and GAP2 (T+23..T+24) SHALL drive PROGEN=0, PROGDATA=0.
REQ-021 LOAD_M SHALL drive PROGEN=1 for T+13..T+22 with PROGDATA = 1, 1, then m_minus1 bits 0..7.
REQ-022 GO SHALL drive PROGEN=1, PROGDATA=0 for exactly cycle T+25.
REQ-023 Only bit ch_sel of PROGEN/PROGDATA SHALL ever be nonzero; all other bits stay 0.
REQ-024 PROGEN/PROGDATA SHALL be driven directly from registers (no combinational path from inputs).
REQ-025 WAIT_DONE SHALL complete on the first cycle where PROGDONE[ch] is 1 and its registered value from the previous cycle is 0 (rising edge), with edge history cleared on entering LOAD_D; done pulses the next cycle, together with ready=1.
REQ-026 A PROGDONE level already high throughout WAIT_DONE SHALL NOT complete the request.
REQ-027 Timeout counter SHALL start at 0 in the first WAIT_DONE cycle and increment each cycle; reaching TIMEOUT-1 without an edge SHALL pulse err with err_code 11 on the next cycle and return to IDLE.
REQ-028 An edge and the timeout on the same cycle SHALL resolve as done, not err.
REQ-029 ready SHALL be 0 from T+1 until the done/err cycle; req while ready=0 SHALL be ignored, not queued.
REQ-030 done and err SHALL never be asserted together; err_code SHALL hold its value until the next err.
REQ-031 PROGDONE of non-selected tiles SHALL be ignored.

Reset
REQ-032 reset=1 SHALL at the next edge force IDLE, ready=1, done=0, err=0, err_code=00, PROGEN=0, PROGDATA=0, timeout counter=0.
REQ-033 reset mid-sequence SHALL abort with no done/err pulse; PROGEN SHALL be 0 from the cycle after reset is sampled.
REQ-034 req on the same edge as reset SHALL be discarded.

Verification
REQ-035 Program ch 1 with M=25 (m_minus1=24), D=8 (d_minus1=7); model PROGDONE rising 40 cycles after GO -> PROGEN[1] serial 1,0,1,1,1,0,0,0,0,0 at T+1..T+10; 1,1,0,0,0,1,1,0,0,0 at T+13..T+22; GO at T+25; done once; PROGEN[0] always 0.
REQ-036 m_minus1=0 -> err=1, err_code=01 at T+1; PROGEN stays 0; ready=1 at T+1.
REQ-037 ch_sel=5 with N_CH=2 -> err_code 10 at T+1; no PROGEN activity.
REQ-038 PROGDONE[0] held at 1 throughout, TIMEOUT=16 -> no done; err with err_code 11 exactly 16 cycles after the first WAIT_DONE cycle.
REQ-039 reset asserted at T+15 -> PROGEN=0 from T+16; no done/err; a new request after reset completes normally.
REQ-040 req held high during busy, then two back-to-back requests -> second accepted only on the done cycle's ready=1; each produces exactly one done.

Source files
------------

// File: rtl/clkgen_prog_ctrl.sv
// Programming sequencer for DCM_CLKGEN tiles: serially loads D and M into one
// selected tile, issues GO, then waits for a PROGDONE rising edge or a timeout.
module clkgen_prog_ctrl #(
    parameter int N_CH    = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            req,
    input  logic [2:0]      ch_sel,
    input  logic [7:0]      m_minus1,
    input  logic [7:0]      d_minus1,
    output logic            ready,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_code,
    output logic [N_CH-1:0] PROGEN,
    output logic [N_CH-1:0] PROGDATA,
    input  logic [N_CH-1:0] PROGDONE
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] E_BAD_M  = 2'b01;
    localparam logic [1:0] E_BAD_CH = 2'b10;
    localparam logic [1:0] E_TMO    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_D,
        S_GAP1,
        S_LOAD_M,
        S_GAP2,
        S_GO,
        S_WAIT
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic [2:0]      ch, ch_nxt;
    logic [7:0]      m_q, m_nxt;
    logic [7:0]      d_q, d_nxt;
    logic            prev_done, prev_nxt;
    logic            done_nxt, err_nxt;
    logic [1:0]      code_nxt;

    logic [N_CH-1:0] ch_mask, mask_nxt;
    logic            sel_done, pdone_rise;
    logic            bad_ch, bad_m;
    logic [9:0]      pat_d, pat_m;
    logic            en_nxt, dat_nxt;

    assign ready = (state == S_IDLE);

    // Decode the latched channel (and the channel about to be latched) to masks.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_mask[i]  = (ch == 3'(i));
            mask_nxt[i] = (ch_nxt == 3'(i));
        end
    end

    assign sel_done   = |(PROGDONE & ch_mask);
    assign pdone_rise = sel_done & ~prev_done;
    assign bad_ch     = ({1'b0, ch_sel} >= 4'(N_CH));
    assign bad_m      = (m_minus1 == 8'd0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tcnt_nxt  = tcnt;
        ch_nxt    = ch;
        m_nxt     = m_q;
        d_nxt     = d_q;
        prev_nxt  = sel_done;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = err_code;

        case (state)
            S_IDLE: begin
                prev_nxt = 1'b0;
                if (req) begin
                    if (bad_ch) begin
                        err_nxt  = 1'b1;
                        code_nxt = E_BAD_CH;
                    end else if (bad_m) begin
                        err_nxt  = 1'b1;
                        code_nxt = E_BAD_M;
                    end else begin
                        state_nxt = S_LOAD_D;
                        cnt_nxt   = 4'd0;
                        ch_nxt    = ch_sel;
                        m_nxt     = m_minus1;
                        d_nxt     = d_minus1;
                    end
                end
            end
            S_LOAD_D: begin
                if (cnt == 4'd9) begin
                    state_nxt = S_GAP1;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_GAP1: begin
                if (cnt == 4'd1) begin
                    state_nxt = S_LOAD_M;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_LOAD_M: begin
                if (cnt == 4'd9) begin
                    state_nxt = S_GAP2;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_GAP2: begin
                if (cnt == 4'd1) begin
                    state_nxt = S_GO;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_GO: begin
                state_nxt = S_WAIT;
                tcnt_nxt  = '0;
            end
            S_WAIT: begin
                // A PROGDONE edge wins over a timeout landing on the same cycle.
                if (pdone_rise) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else if (tcnt == T_LAST) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                    code_nxt  = E_TMO;
                    tcnt_nxt  = '0;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Serial frames are LSB first: D frame leads with 1,0 and M frame with 1,1.
    assign pat_d = {d_nxt, 2'b01};
    assign pat_m = {m_nxt, 2'b11};

    always_comb begin
        en_nxt  = 1'b0;
        dat_nxt = 1'b0;
        case (state_nxt)
            S_LOAD_D: begin
                en_nxt  = 1'b1;
                dat_nxt = pat_d[cnt_nxt];
            end
            S_LOAD_M: begin
                en_nxt  = 1'b1;
                dat_nxt = pat_m[cnt_nxt];
            end
            S_GO:     en_nxt = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            tcnt      <= '0;
            ch        <= 3'd0;
            m_q       <= 8'd0;
            d_q       <= 8'd0;
            prev_done <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            PROGEN    <= '0;
            PROGDATA  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tcnt      <= tcnt_nxt;
            ch        <= ch_nxt;
            m_q       <= m_nxt;
            d_q       <= d_nxt;
            prev_done <= prev_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            err_code  <= code_nxt;
            PROGEN    <= en_nxt ? mask_nxt : '0;
            PROGDATA  <= (en_nxt & dat_nxt) ? mask_nxt : '0;
        end
    end

endmodule

// File: tb/tb_clkgen_prog_ctrl.sv
// Directed bench for clkgen_prog_ctrl: one default instance, one with TIMEOUT=16.
module tb_clkgen_prog_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [2:0] ch_sel = 3'd0;
    logic [7:0] m1 = 8'd0, d1 = 8'd0;
    logic [1:0] pd_a = 2'b00, pd_b = 2'b00;

    logic       ready_a, done_a, err_a, ready_b, done_b, err_b;
    logic [1:0] code_a, code_b, en_a, dat_a, en_b, dat_b;

    int checks = 0;
    int failures = 0;

    // Expected PROGEN / PROGDATA of the selected tile for T+1..T+25 (ch1, M-1=24, D-1=7).
    int exp_en [25] = '{1,1,1,1,1,1,1,1,1,1, 0,0, 1,1,1,1,1,1,1,1,1,1, 0,0, 1};
    int exp_dt [25] = '{1,0,1,1,1,0,0,0,0,0, 0,0, 1,1,0,0,0,1,1,0,0,0, 0,0, 0};

    always #5 clk = ~clk;

    clkgen_prog_ctrl #(.N_CH(2)) u_dut_a (
        .CLK(clk), .reset(reset), .req(req_a), .ch_sel(ch_sel),
        .m_minus1(m1), .d_minus1(d1), .ready(ready_a), .done(done_a),
        .err(err_a), .err_code(code_a), .PROGEN(en_a), .PROGDATA(dat_a),
        .PROGDONE(pd_a)
    );

    clkgen_prog_ctrl #(.N_CH(2), .TIMEOUT(16)) u_dut_b (
        .CLK(clk), .reset(reset), .req(req_b), .ch_sel(ch_sel),
        .m_minus1(m1), .d_minus1(d1), .ready(ready_b), .done(done_b),
        .err(err_b), .err_code(code_b), .PROGEN(en_b), .PROGDATA(dat_b),
        .PROGDONE(pd_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge; returns at the negedge showing cycle T+1.
    task automatic issue(input bit on_b, input logic [2:0] ch, input logic [7:0] m, input logic [7:0] d);
        ch_sel = ch; m1 = m; d1 = d;
        if (on_b) req_b = 1'b1; else req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
    endtask

    // Full ch1 programming on dut A with PROGDONE[1] rising 40 cycles after GO.
    task automatic run_full(input string tag);
        int nd = 0, ne = 0, stray = 0;
        issue(1'b0, 3'd1, 8'd24, 8'd7);
        for (int k = 1; k <= 80; k++) begin
            if (k <= 25)
                chk({tag, "_seq"}, {28'd0, en_a, dat_a},
                    {28'd0, exp_en[k-1] != 0, 1'b0, exp_dt[k-1] != 0, 1'b0});
            else if (en_a != 2'b00 || dat_a != 2'b00)
                stray++;
            if (k == 1)  chk({tag, "_busy"}, ready_a, 1'b0);
            if (k == 66) chk({tag, "_done"}, {done_a, ready_a}, 2'b11);
            nd += done_a; ne += err_a;
            if (k == 30) pd_a[0] = 1'b1;
            if (k == 65) pd_a[1] = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_ndone"}, nd, 1);
        chk({tag, "_nerr"}, ne, 0);
        chk({tag, "_idle_en"}, stray, 0);
        pd_a = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        int nd, ne, act;
        repeat (3) @(negedge clk);
        chk("rst_a", {27'd0, ready_a, done_a, err_a, code_a, en_a, dat_a}, {27'd0, 3'b100, 2'b00, 4'b0000});
        chk("rst_b", {27'd0, ready_b, done_b, err_b, code_b, en_b, dat_b}, {27'd0, 3'b100, 2'b00, 4'b0000});
        reset = 1'b0;
        @(negedge clk);

        run_full("prog1");

        // M-1 = 0 rejected
        issue(1'b0, 3'd0, 8'd0, 8'd5);
        chk("badm_t1", {26'd0, err_a, done_a, ready_a, code_a, en_a}, {26'd0, 3'b101, 2'b01, 2'b00});
        @(negedge clk);
        chk("badm_hold", {28'd0, err_a, ready_a, code_a}, {28'd0, 2'b01, 2'b01});

        // Bad channel, including the N_CH boundary and priority over bad M
        issue(1'b0, 3'd5, 8'd24, 8'd7);
        chk("badch5", {28'd0, err_a, ready_a, code_a}, {28'd0, 2'b11, 2'b10});
        act = 0;
        for (int k = 0; k < 12; k++) begin
            act += (en_a != 0);
            @(negedge clk);
        end
        chk("badch_noen", act, 0);
        issue(1'b0, 3'd2, 8'd24, 8'd7);
        chk("badch2", {29'd0, err_a, code_a}, {29'd0, 1'b1, 2'b10});
        @(negedge clk);
        issue(1'b0, 3'd5, 8'd0, 8'd7);
        chk("badch_prio", {29'd0, err_a, code_a}, {29'd0, 1'b1, 2'b10});
        @(negedge clk);

        // Timeout with PROGDONE held high on dut B
        pd_b = 2'b01;
        @(negedge clk);
        issue(1'b1, 3'd0, 8'd1, 8'd0);
        nd = 0; ne = 0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 41) chk("tmo_early", err_b, 1'b0);
            if (k == 42) chk("tmo_err", {28'd0, err_b, ready_b, code_b}, {28'd0, 2'b11, 2'b11});
            nd += done_b; ne += err_b;
            @(negedge clk);
        end
        chk("tmo_ndone", nd, 0);
        chk("tmo_nerr", ne, 1);
        pd_b = 2'b00;

        // Reset mid-sequence, then a normal run
        issue(1'b0, 3'd1, 8'd24, 8'd7);
        nd = 0; ne = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 15) begin
                chk("rst_mid_pre", en_a, 2'b10);
                reset = 1'b1;
            end
            if (k == 16) begin
                chk("rst_mid_en", {29'd0, en_a, ready_a}, {29'd0, 2'b00, 1'b1});
                reset = 1'b0;
            end
            if (k >= 16) begin nd += done_a; ne += err_a; end
            @(negedge clk);
        end
        chk("rst_mid_pulses", nd + ne, 0);
        run_full("prog2");

        // req on the same edge as reset is dropped
        reset = 1'b1; req_a = 1'b1; ch_sel = 3'd1; m1 = 8'd24; d1 = 8'd7;
        @(negedge clk);
        reset = 1'b0; req_a = 1'b0;
        chk("rst_req1", {29'd0, en_a, ready_a}, {29'd0, 2'b00, 1'b1});
        @(negedge clk);
        chk("rst_req2", {29'd0, en_a, ready_a}, {29'd0, 2'b00, 1'b1});

        // req held through busy; second request taken on the done cycle
        issue(1'b0, 3'd1, 8'd24, 8'd7);
        req_a = 1'b1;
        nd = 0; ne = 0;
        for (int k = 1; k <= 75; k++) begin
            if (k == 5)  chk("hold_busy", {31'd0, ready_a}, 32'd0);
            if (k == 31) chk("hold_done1", {30'd0, done_a, ready_a}, {30'd0, 2'b11});
            if (k == 32) chk("hold_acc2", {27'd0, ready_a, en_a, dat_a}, {27'd0, 1'b0, 4'b1010});
            if (k == 62) chk("hold_done2", done_a, 1'b1);
            if (k == 70) chk("hold_idle", ready_a, 1'b1);
            nd += done_a; ne += err_a;
            req_a = (k <= 31);
            pd_a[1] = (k == 30 || k == 31 || (k >= 61 && k <= 63));
            @(negedge clk);
        end
        chk("hold_ndone", nd, 2);
        chk("hold_nerr", ne, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
